// File: rtl/fp_det_pkg.sv
// fp_det_pkg: shared commands, FSM states, address-field layout and defaults for the FP determinant sequencer
package fp_det_pkg;
  localparam int MAX_N = 5;
  localparam int TIMEOUT = 1024;
  localparam logic [31:0] NAN_WORD = 32'h7FC0_0000;
  localparam int ROW_LSB = 0;
  localparam int COL_LSB = 3;
  localparam int FIELD_W = 3;
  typedef enum logic [4:0] {
    CMD_WRITE  = 5'd0,
    CMD_SETDIM = 5'd1,
    CMD_RUN    = 5'd2,
    CMD_READ   = 5'd3,
    CMD_CLEAR  = 5'd4
  } cmd_e;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/fp_det_wdog.sv
// fp_det_wdog: engine watchdog counter; clr reloads zero, en counts, expired flags TIMEOUT-1 (clk, reset, clr, en -> expired)
module fp_det_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] count;
  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (en) count <= count + 1'b1;
  end
  assign expired = count == W'(TIMEOUT - 1);
endmodule

// File: rtl/fp_det_seq.sv
// fp_det_seq: custom-instruction sequencer owning the matrix store (cpu: start/n/dataa/datab -> done/result/busy; engine: eng_start/eng_dim/eng_data out, eng_row/eng_col/eng_done/eng_result in)
module fp_det_seq #(
  parameter int MAX_N = fp_det_pkg::MAX_N,
  parameter int TIMEOUT = fp_det_pkg::TIMEOUT,
  parameter logic [31:0] NAN_WORD = fp_det_pkg::NAN_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [4:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic        eng_start,
  output logic [2:0]  eng_dim,
  input  logic [2:0]  eng_row,
  input  logic [2:0]  eng_col,
  output logic [31:0] eng_data,
  input  logic        eng_done,
  input  logic [31:0] eng_result,
  output logic        busy
);
  import fp_det_pkg::*;
  localparam int CELLS = MAX_N * MAX_N;
  localparam int IW = $clog2(CELLS);
  logic [31:0] mat [CELLS];
  state_e state;
  logic [2:0] dim, row, col;
  logic timeout_flag, expired, addr_ok, dim_ok, flag_addr, eng_ok, unused;
  logic [IW-1:0] idx, eng_idx;
  logic [31:0] cmd_result;
  assign row = datab[ROW_LSB +: FIELD_W];
  assign col = datab[COL_LSB +: FIELD_W];
  assign addr_ok = 32'(row) < MAX_N && 32'(col) < MAX_N;
  assign flag_addr = &{row, col};
  assign dim_ok = dataa[2:0] != 3'd0 && 32'(dataa[2:0]) <= MAX_N;
  assign idx = IW'(32'(row) * MAX_N + 32'(col));
  assign eng_ok = 32'(eng_row) < MAX_N && 32'(eng_col) < MAX_N;
  assign eng_idx = IW'(32'(eng_row) * MAX_N + 32'(eng_col));
  assign eng_data = eng_ok ? mat[eng_idx] : '0;
  assign eng_dim = dim;
  assign unused = ^datab[31:6];
  assign cmd_result = n == CMD_WRITE  ? (addr_ok ? dataa : NAN_WORD)
                    : n == CMD_SETDIM ? (dim_ok ? '0 : NAN_WORD)
                    : n == CMD_READ   ? (addr_ok ? mat[idx] : flag_addr ? 32'(timeout_flag) : NAN_WORD)
                    : n == CMD_CLEAR  ? '0 : NAN_WORD;
  fp_det_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .reset(reset),
    .clr(clk_en && state == S_LAUNCH),
    .en(clk_en && state == S_WAIT),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      done <= 1'b0;
      result <= '0;
      eng_start <= 1'b0;
      busy <= 1'b0;
      dim <= 3'd1;
      timeout_flag <= 1'b0;
      for (int i = 0; i < CELLS; i++) mat[i] <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      eng_start <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          state <= n == CMD_RUN ? S_LAUNCH : S_RESP;
          eng_start <= n == CMD_RUN;
          done <= n != CMD_RUN;
          if (n != CMD_RUN) result <= cmd_result;
          if (n == CMD_WRITE && addr_ok) mat[idx] <= dataa;
          if (n == CMD_SETDIM && dim_ok) dim <= dataa[2:0];
          if (n == CMD_CLEAR) begin
            dim <= 3'd1;
            timeout_flag <= 1'b0;
            for (int i = 0; i < CELLS; i++) mat[i] <= '0;
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: if (eng_done || expired) begin
          state <= S_RESP;
          done <= 1'b1;
          result <= eng_done ? eng_result : NAN_WORD;
          timeout_flag <= timeout_flag | ~eng_done;
        end
        S_RESP: begin
          busy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
